// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the MIPS instruction encoder: mnemonic indices,
// opcode/funct constants, format classes and field-usage masks.
package instr_encoder_pkg;

    typedef enum logic [5:0] {
        MN_ADD, MN_ADDU, MN_SUB, MN_SUBU, MN_AND, MN_OR, MN_XOR, MN_NOR,
        MN_SLT, MN_SLTU, MN_MULT, MN_MULTU, MN_DIV, MN_DIVU,
        MN_JR, MN_JALR, MN_MFHI, MN_MFLO, MN_SLL, MN_SRL, MN_SRA,
        MN_LB, MN_LH, MN_LW, MN_LBU, MN_LHU, MN_SB, MN_SH, MN_SW,
        MN_ADDI, MN_ADDIU, MN_SLTI, MN_SLTIU, MN_ANDI, MN_ORI, MN_XORI, MN_LUI,
        MN_BEQ, MN_BNE, MN_BLEZ, MN_BGTZ, MN_BLTZ, MN_BGEZ, MN_J, MN_JAL
    } mnem_e;

    localparam int unsigned MNEM_COUNT = 45;

    typedef enum logic [2:0] {
        FMT_R, FMT_SHIFT, FMT_I, FMT_REGIMM, FMT_J, FMT_NONE
    } fmt_e;

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02,
                           OP_JAL     = 6'h03, OP_BEQ    = 6'h04, OP_BNE   = 6'h05,
                           OP_BLEZ    = 6'h06, OP_BGTZ   = 6'h07, OP_ADDI  = 6'h08,
                           OP_ADDIU   = 6'h09, OP_SLTI   = 6'h0A, OP_SLTIU = 6'h0B,
                           OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_XORI  = 6'h0E,
                           OP_LUI     = 6'h0F, OP_LB     = 6'h20, OP_LH    = 6'h21,
                           OP_LW      = 6'h23, OP_LBU    = 6'h24, OP_LHU   = 6'h25,
                           OP_SB      = 6'h28, OP_SH     = 6'h29, OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL   = 6'h02, FN_SRA  = 6'h03,
                           FN_JR   = 6'h08, FN_JALR  = 6'h09, FN_MFHI = 6'h10,
                           FN_MFLO = 6'h12, FN_MULT  = 6'h18, FN_MULTU = 6'h19,
                           FN_DIV  = 6'h1A, FN_DIVU  = 6'h1B, FN_ADD  = 6'h20,
                           FN_ADDU = 6'h21, FN_SUB   = 6'h22, FN_SUBU = 6'h23,
                           FN_AND  = 6'h24, FN_OR    = 6'h25, FN_XOR  = 6'h26,
                           FN_NOR  = 6'h27, FN_SLT   = 6'h2A, FN_SLTU = 6'h2B;

    localparam logic [4:0] RT_BLTZ = 5'd0, RT_BGEZ = 5'd1;

    // Field-usage masks {rs, rt, rd}; a cleared bit forces that field to zero
    localparam logic [2:0] FLD_ALU  = 3'b111, FLD_MUL = 3'b110, FLD_JR  = 3'b100,
                           FLD_JALR = 3'b101, FLD_MF  = 3'b001, FLD_SH  = 3'b011,
                           FLD_IMM  = 3'b110, FLD_LUI = 3'b010, FLD_BZ  = 3'b100;

    function automatic logic is_reg_format(input fmt_e f);
        return (f == FMT_R) || (f == FMT_SHIFT);
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small output FIFO of {addr, ir} entries; DEPTH must be a power of two (2 or 4).
// No bypass: a push is refused while full even if the head is popped that cycle.
module instr_fifo
    import instr_encoder_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             valid,
    output logic [WIDTH-1:0] head_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign valid   = (count_reg != '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && valid && !flush;

    // Empty FIFO presents zeros so no stale word is ever visible
    assign head_data = valid ? mem[rd_ptr_reg] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// MIPS instruction encoder: combinational encode table, address counter and output FIFO.
// Optional ENCODER_CHECK_EN macro enables the sticky field-check err flag.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
    parameter int          DEPTH     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_mnem,
    input  logic [4:0]  req_rs,
    input  logic [4:0]  req_rt,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_sa,
    input  logic [15:0] req_imm,
    input  logic [25:0] req_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ir,
    output logic [31:0] out_addr,
    output logic        err
);

    fmt_e        fmt;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [2:0]  fld;
    logic [4:0]  rt_fix;
    logic [4:0]  rs_f;
    logic [4:0]  rt_f;
    logic [4:0]  rd_f;
    logic [31:0] enc_word;
    logic [31:0] addr_reg;
    logic        fifo_full;
    logic        push;
    logic [63:0] head_data;

    always_comb begin
        fmt    = FMT_NONE;
        op     = OP_SPECIAL;
        fn     = 6'h00;
        fld    = 3'b000;
        rt_fix = 5'd0;
        case (req_mnem)
            MN_ADD:   begin fmt = FMT_R; fn = FN_ADD;   fld = FLD_ALU; end
            MN_ADDU:  begin fmt = FMT_R; fn = FN_ADDU;  fld = FLD_ALU; end
            MN_SUB:   begin fmt = FMT_R; fn = FN_SUB;   fld = FLD_ALU; end
            MN_SUBU:  begin fmt = FMT_R; fn = FN_SUBU;  fld = FLD_ALU; end
            MN_AND:   begin fmt = FMT_R; fn = FN_AND;   fld = FLD_ALU; end
            MN_OR:    begin fmt = FMT_R; fn = FN_OR;    fld = FLD_ALU; end
            MN_XOR:   begin fmt = FMT_R; fn = FN_XOR;   fld = FLD_ALU; end
            MN_NOR:   begin fmt = FMT_R; fn = FN_NOR;   fld = FLD_ALU; end
            MN_SLT:   begin fmt = FMT_R; fn = FN_SLT;   fld = FLD_ALU; end
            MN_SLTU:  begin fmt = FMT_R; fn = FN_SLTU;  fld = FLD_ALU; end
            MN_MULT:  begin fmt = FMT_R; fn = FN_MULT;  fld = FLD_MUL; end
            MN_MULTU: begin fmt = FMT_R; fn = FN_MULTU; fld = FLD_MUL; end
            MN_DIV:   begin fmt = FMT_R; fn = FN_DIV;   fld = FLD_MUL; end
            MN_DIVU:  begin fmt = FMT_R; fn = FN_DIVU;  fld = FLD_MUL; end
            MN_JR:    begin fmt = FMT_R; fn = FN_JR;    fld = FLD_JR;  end
            MN_JALR:  begin fmt = FMT_R; fn = FN_JALR;  fld = FLD_JALR; end
            MN_MFHI:  begin fmt = FMT_R; fn = FN_MFHI;  fld = FLD_MF;  end
            MN_MFLO:  begin fmt = FMT_R; fn = FN_MFLO;  fld = FLD_MF;  end
            MN_SLL:   begin fmt = FMT_SHIFT; fn = FN_SLL; fld = FLD_SH; end
            MN_SRL:   begin fmt = FMT_SHIFT; fn = FN_SRL; fld = FLD_SH; end
            MN_SRA:   begin fmt = FMT_SHIFT; fn = FN_SRA; fld = FLD_SH; end
            MN_LB:    begin fmt = FMT_I; op = OP_LB;    fld = FLD_IMM; end
            MN_LH:    begin fmt = FMT_I; op = OP_LH;    fld = FLD_IMM; end
            MN_LW:    begin fmt = FMT_I; op = OP_LW;    fld = FLD_IMM; end
            MN_LBU:   begin fmt = FMT_I; op = OP_LBU;   fld = FLD_IMM; end
            MN_LHU:   begin fmt = FMT_I; op = OP_LHU;   fld = FLD_IMM; end
            MN_SB:    begin fmt = FMT_I; op = OP_SB;    fld = FLD_IMM; end
            MN_SH:    begin fmt = FMT_I; op = OP_SH;    fld = FLD_IMM; end
            MN_SW:    begin fmt = FMT_I; op = OP_SW;    fld = FLD_IMM; end
            MN_ADDI:  begin fmt = FMT_I; op = OP_ADDI;  fld = FLD_IMM; end
            MN_ADDIU: begin fmt = FMT_I; op = OP_ADDIU; fld = FLD_IMM; end
            MN_SLTI:  begin fmt = FMT_I; op = OP_SLTI;  fld = FLD_IMM; end
            MN_SLTIU: begin fmt = FMT_I; op = OP_SLTIU; fld = FLD_IMM; end
            MN_ANDI:  begin fmt = FMT_I; op = OP_ANDI;  fld = FLD_IMM; end
            MN_ORI:   begin fmt = FMT_I; op = OP_ORI;   fld = FLD_IMM; end
            MN_XORI:  begin fmt = FMT_I; op = OP_XORI;  fld = FLD_IMM; end
            MN_LUI:   begin fmt = FMT_I; op = OP_LUI;   fld = FLD_LUI; end
            MN_BEQ:   begin fmt = FMT_I; op = OP_BEQ;   fld = FLD_IMM; end
            MN_BNE:   begin fmt = FMT_I; op = OP_BNE;   fld = FLD_IMM; end
            MN_BLEZ:  begin fmt = FMT_I; op = OP_BLEZ;  fld = FLD_BZ;  end
            MN_BGTZ:  begin fmt = FMT_I; op = OP_BGTZ;  fld = FLD_BZ;  end
            MN_BLTZ:  begin fmt = FMT_REGIMM; op = OP_REGIMM; fld = FLD_BZ; rt_fix = RT_BLTZ; end
            MN_BGEZ:  begin fmt = FMT_REGIMM; op = OP_REGIMM; fld = FLD_BZ; rt_fix = RT_BGEZ; end
            MN_J:     begin fmt = FMT_J; op = OP_J;   end
            MN_JAL:   begin fmt = FMT_J; op = OP_JAL; end
            default:  begin fmt = FMT_NONE; end
        endcase
    end

    assign rs_f = fld[2] ? req_rs : 5'd0;
    assign rt_f = fld[1] ? req_rt : rt_fix;
    assign rd_f = fld[0] ? req_rd : 5'd0;

    always_comb begin
        enc_word = 32'h0000_0000;
        case (fmt)
            FMT_R:             enc_word = {OP_SPECIAL, rs_f, rt_f, rd_f, 5'd0, fn};
            FMT_SHIFT:         enc_word = {OP_SPECIAL, rs_f, rt_f, rd_f, req_sa, fn};
            FMT_I, FMT_REGIMM: enc_word = {op, rs_f, rt_f, req_imm};
            FMT_J:             enc_word = {op, req_target};
            default:           enc_word = 32'h0000_0000;
        endcase
    end

    assign req_ready = !fifo_full;
    // Flush wins: a request handshaken during flush is dropped, not queued
    assign push      = req_valid && req_ready && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_reg <= BASE_ADDR;
        end else if (flush) begin
            addr_reg <= BASE_ADDR;
        end else if (push) begin
            addr_reg <= addr_reg + 32'd4;
        end
    end

`ifdef ENCODER_CHECK_EN
    logic field_bad;
    logic err_reg;

    assign field_bad = (fmt == FMT_NONE)
                    || ((req_sa != 5'd0) && (fmt != FMT_SHIFT))
                    || ((req_rd != 5'd0) && !is_reg_format(fmt));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_reg <= 1'b0;
        end else if (push && field_bad) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .push_data ({addr_reg, enc_word}),
        .pop       (out_ready),
        .full      (fifo_full),
        .valid     (out_valid),
        .head_data (head_data)
    );

    assign out_addr = head_data[63:32];
    assign out_ir   = head_data[31:0];

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: queue-based reference model checked every
// cycle, directed literal cases, randomized traffic, and an address-wrap instance.
`timescale 1ns/1ps
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] BASE  = 32'h0000_3000;
`ifdef ENCODER_CHECK_EN
    localparam bit CHECK_ON = 1'b1;
`else
    localparam bit CHECK_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [5:0]  req_mnem = 6'd0;
    logic [4:0]  req_rs = 5'd0, req_rt = 5'd0, req_rd = 5'd0, req_sa = 5'd0;
    logic [15:0] req_imm = 16'd0;
    logic [25:0] req_target = 26'd0;
    logic        req_ready, out_valid, err;
    logic [31:0] out_ir, out_addr;

    logic        w_req_valid = 1'b0, w_out_ready = 1'b0, w_flush = 1'b0;
    logic        w_req_ready, w_out_valid, w_err;
    logic [31:0] w_out_ir, w_out_addr;

    typedef struct { logic [31:0] addr; logic [31:0] ir; } ent_t;
    ent_t        q[$];
    logic [31:0] m_addr = BASE;
    logic        m_err = 1'b0;
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_mnem(req_mnem),
        .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_sa(req_sa),
        .req_imm(req_imm), .req_target(req_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_ir(out_ir),
        .out_addr(out_addr), .err(err)
    );

    instr_encoder #(.BASE_ADDR(32'hFFFF_FFFC), .DEPTH(4)) dut_wrap (
        .clk(clk), .reset(reset), .flush(w_flush),
        .req_valid(w_req_valid), .req_ready(w_req_ready), .req_mnem(req_mnem),
        .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_sa(req_sa),
        .req_imm(req_imm), .req_target(req_target),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_ir(w_out_ir),
        .out_addr(w_out_addr), .err(w_err)
    );

    function automatic logic [31:0] r_w(input logic [4:0] s, t, d, h, input logic [5:0] f);
        return {6'h00, s, t, d, h, f};
    endfunction

    function automatic logic [31:0] i_w(input logic [5:0] o, input logic [4:0] s, t,
                                        input logic [15:0] i);
        return {o, s, t, i};
    endfunction

    // MIPS encoding straight from the format rules; bad flags a field-check violation
    function automatic logic [31:0] ref_enc(input logic [5:0] m, input logic [4:0] s, t, d, h,
                                            input logic [15:0] i, input logic [25:0] g,
                                            output bit bad);
        logic [31:0] w;
        bit known, is_r, is_shift;
        w = 32'h0;
        known = 1'b1;
        case (m)
            MN_ADD:   w = r_w(s, t, d, 5'd0, 6'h20);
            MN_ADDU:  w = r_w(s, t, d, 5'd0, 6'h21);
            MN_SUB:   w = r_w(s, t, d, 5'd0, 6'h22);
            MN_SUBU:  w = r_w(s, t, d, 5'd0, 6'h23);
            MN_AND:   w = r_w(s, t, d, 5'd0, 6'h24);
            MN_OR:    w = r_w(s, t, d, 5'd0, 6'h25);
            MN_XOR:   w = r_w(s, t, d, 5'd0, 6'h26);
            MN_NOR:   w = r_w(s, t, d, 5'd0, 6'h27);
            MN_SLT:   w = r_w(s, t, d, 5'd0, 6'h2A);
            MN_SLTU:  w = r_w(s, t, d, 5'd0, 6'h2B);
            MN_MULT:  w = r_w(s, t, 5'd0, 5'd0, 6'h18);
            MN_MULTU: w = r_w(s, t, 5'd0, 5'd0, 6'h19);
            MN_DIV:   w = r_w(s, t, 5'd0, 5'd0, 6'h1A);
            MN_DIVU:  w = r_w(s, t, 5'd0, 5'd0, 6'h1B);
            MN_JR:    w = r_w(s, 5'd0, 5'd0, 5'd0, 6'h08);
            MN_JALR:  w = r_w(s, 5'd0, d, 5'd0, 6'h09);
            MN_MFHI:  w = r_w(5'd0, 5'd0, d, 5'd0, 6'h10);
            MN_MFLO:  w = r_w(5'd0, 5'd0, d, 5'd0, 6'h12);
            MN_SLL:   w = r_w(5'd0, t, d, h, 6'h00);
            MN_SRL:   w = r_w(5'd0, t, d, h, 6'h02);
            MN_SRA:   w = r_w(5'd0, t, d, h, 6'h03);
            MN_LB:    w = i_w(6'h20, s, t, i);
            MN_LH:    w = i_w(6'h21, s, t, i);
            MN_LW:    w = i_w(6'h23, s, t, i);
            MN_LBU:   w = i_w(6'h24, s, t, i);
            MN_LHU:   w = i_w(6'h25, s, t, i);
            MN_SB:    w = i_w(6'h28, s, t, i);
            MN_SH:    w = i_w(6'h29, s, t, i);
            MN_SW:    w = i_w(6'h2B, s, t, i);
            MN_ADDI:  w = i_w(6'h08, s, t, i);
            MN_ADDIU: w = i_w(6'h09, s, t, i);
            MN_SLTI:  w = i_w(6'h0A, s, t, i);
            MN_SLTIU: w = i_w(6'h0B, s, t, i);
            MN_ANDI:  w = i_w(6'h0C, s, t, i);
            MN_ORI:   w = i_w(6'h0D, s, t, i);
            MN_XORI:  w = i_w(6'h0E, s, t, i);
            MN_LUI:   w = i_w(6'h0F, 5'd0, t, i);
            MN_BEQ:   w = i_w(6'h04, s, t, i);
            MN_BNE:   w = i_w(6'h05, s, t, i);
            MN_BLEZ:  w = i_w(6'h06, s, 5'd0, i);
            MN_BGTZ:  w = i_w(6'h07, s, 5'd0, i);
            MN_BLTZ:  w = i_w(6'h01, s, 5'd0, i);
            MN_BGEZ:  w = i_w(6'h01, s, 5'd1, i);
            MN_J:     w = {6'h02, g};
            MN_JAL:   w = {6'h03, g};
            default:  known = 1'b0;
        endcase
        is_shift = (m == MN_SLL) || (m == MN_SRL) || (m == MN_SRA);
        is_r     = known && (w[31:26] == 6'h00);
        bad      = !known || ((h != 5'd0) && !is_shift) || ((d != 5'd0) && !is_r);
        return w;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [5:0] m, input logic [4:0] s, t, d, h,
                        input logic [15:0] i, input logic [25:0] g);
        int guard;
        guard = 0;
        req_mnem = m; req_rs = s; req_rt = t; req_rd = d; req_sa = h;
        req_imm = i; req_target = g; req_valid = 1'b1;
        while (!req_ready) begin
            step();
            guard++;
            if (guard > 20) begin
                n_vec++; n_bad++;
                $display("FAIL send_timeout: req_ready stayed 0, expected 1 within 20 cycles");
                break;
            end
        end
        step();
        req_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    // Reference model: advances on each clock edge from the inputs seen at that edge
    initial forever begin
        bit full_now, pop_now, bad;
        logic [31:0] w;
        @(posedge clk or posedge reset);
        if (reset) begin
            q.delete();
            m_addr = BASE;
            m_err  = 1'b0;
        end else if (flush) begin
            q.delete();
            m_addr = BASE;
        end else begin
            full_now = (q.size() >= DEPTH);
            pop_now  = (q.size() != 0) && out_ready;
            w = ref_enc(req_mnem, req_rs, req_rt, req_rd, req_sa, req_imm, req_target, bad);
            if (pop_now) begin
                $display("pop  addr=%h ir=%h", q[0].addr, q[0].ir);
                void'(q.pop_front());
            end
            if (req_valid && !full_now) begin
                q.push_back('{m_addr, w});
                m_addr = m_addr + 32'd4;
                if (CHECK_ON && bad) m_err = 1'b1;
            end
        end
    end

    // Per-cycle comparison of the DUT against the model
    initial forever begin
        @(negedge clk);
        chk("req_ready", 64'(req_ready), 64'(q.size() < DEPTH));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_ir", 64'(out_ir), 64'(q[0].ir));
            chk("out_addr", 64'(out_addr), 64'(q[0].addr));
        end
        chk("err", 64'(err), 64'(m_err));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1'b1;
        step(); step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_ir", 64'(out_ir), 64'd0);
        chk("rst_out_addr", 64'(out_addr), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_err", 64'(err), 64'd0);

        send(MN_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
        @(negedge clk);
        chk("addu_ir", 64'(out_ir), 64'h0022_1821);
        chk("addu_addr", 64'(out_addr), 64'h0000_3000);
        pop_one();
        flush = 1'b1; step(); flush = 1'b0;

        send(MN_ORI, 5'd0, 5'd8, 5'd0, 5'd0, 16'h1234, 26'd0);
        send(MN_LUI, 5'd0, 5'd1, 5'd0, 5'd0, 16'h8000, 26'd0);
        @(negedge clk);
        chk("ori_ir", 64'(out_ir), 64'h3408_1234);
        chk("ori_addr", 64'(out_addr), 64'h0000_3000);
        chk("full_ready", 64'(req_ready), 64'd0);
        pop_one();
        @(negedge clk);
        chk("lui_ir", 64'(out_ir), 64'h3C01_8000);
        chk("lui_addr", 64'(out_addr), 64'h0000_3004);
        pop_one();

        flush = 1'b1; step(); flush = 1'b0;
        send(MN_BGEZ, 5'd5, 5'd0, 5'd0, 5'd0, 16'hFFFF, 26'd0);
        @(negedge clk);
        chk("bgez_ir", 64'(out_ir), 64'h04A1_FFFF);
        pop_one();
        send(MN_J, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h000_0C00);
        @(negedge clk);
        chk("j_ir", 64'(out_ir), 64'h0800_0C00);
        chk("j_addr", 64'(out_addr), 64'h0000_3004);
        pop_one();

        // Back-pressure: DEPTH+1 requests with the consumer stalled
        flush = 1'b1; step(); flush = 1'b0;
        req_mnem = MN_ADDU; req_rs = 5'd1; req_rt = 5'd2; req_rd = 5'd3; req_sa = 5'd0;
        req_valid = 1'b1;
        step(); step(); step();
        @(negedge clk);
        chk("bp_ready_low", 64'(req_ready), 64'd0);
        chk("bp_head_addr", 64'(out_addr), 64'h0000_3000);
        out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("bp_drain1_addr", 64'(out_addr), 64'h0000_3004);
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk("bp_drain2_addr", 64'(out_addr), 64'h0000_3008);
        step();
        out_ready = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            req_valid  = ($urandom_range(0, 3) != 0);
            req_mnem   = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(MNEM_COUNT, 63))
                                                     : 6'($urandom_range(0, MNEM_COUNT - 1));
            req_rs     = 5'($urandom);
            req_rt     = 5'($urandom);
            req_rd     = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
            req_sa     = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
            req_imm    = 16'($urandom);
            req_target = 26'($urandom);
            out_ready  = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 59) == 0);
            reset      = ($urandom_range(0, 399) == 0);
            step();
        end
        req_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        reset = 1'b1; step(); reset = 1'b0;

        // Field check: ADD with a nonzero shamt
        send(MN_ADD, 5'd0, 5'd0, 5'd0, 5'd3, 16'd0, 26'd0);
        @(negedge clk);
        chk("chk_ir", 64'(out_ir), 64'h0000_0020);
        chk("chk_err", 64'(err), 64'(CHECK_ON));
        flush = 1'b1; step(); flush = 1'b0;
        @(negedge clk);
        chk("chk_err_flush", 64'(err), 64'(CHECK_ON));
        reset = 1'b1; step(); reset = 1'b0;
        @(negedge clk);
        chk("chk_err_reset", 64'(err), 64'd0);

        // Address wrap on the second instance
        req_mnem = MN_ADDU; req_rs = 5'd1; req_rt = 5'd2; req_rd = 5'd3; req_sa = 5'd0;
        w_req_valid = 1'b1;
        step(); step(); step(); step(); step();
        w_req_valid = 1'b0;
        @(negedge clk);
        chk("wrap_ready_low", 64'(w_req_ready), 64'd0);
        chk("wrap_first_addr", 64'(w_out_addr), 64'hFFFF_FFFC);
        chk("wrap_first_ir", 64'(w_out_ir), 64'h0022_1821);
        w_out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("wrap_second_addr", 64'(w_out_addr), 64'h0000_0000);
        step();
        @(negedge clk);
        chk("wrap_third_addr", 64'(w_out_addr), 64'h0000_0004);
        w_out_ready = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
